instr_queue: RTL and testbench

//   Dual-issue instruction buffer between the instruction fetch unit and decode.

---
 rtl/instr_queue_if.sv | 28 ++
 rtl/instr_queue.sv | 91 +++++++++
 tb/tb_instr_queue.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/instr_queue_if.sv
// Fetch/decode-facing signal bundle of the dual-issue instruction queue.
// The queue uses the slave view; the fetch/decode side (or a bench) uses master.
interface instr_queue_if #(
  parameter int INST_W = 32,
  parameter int CNT_W  = 4
);
  logic [INST_W-1:0] inst0_i;
  logic [INST_W-1:0] inst1_i;
  logic              inst_valid_i;
  logic              ready_o;
  logic              flush_i;
  logic [INST_W-1:0] deq0_o;
  logic              deq0_valid_o;
  logic [INST_W-1:0] deq1_o;
  logic              deq1_valid_o;
  logic [1:0]        pop_i;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  inst0_i, inst1_i, inst_valid_i, flush_i, pop_i,
    output ready_o, deq0_o, deq0_valid_o, deq1_o, deq1_valid_o, count_o
  );

  modport master (
    output inst0_i, inst1_i, inst_valid_i, flush_i, pop_i,
    input  ready_o, deq0_o, deq0_valid_o, deq1_o, deq1_valid_o, count_o
  );
endinterface

// File: rtl/instr_queue.sv
// Dual-issue instruction buffer: accepts a two-instruction fetch packet per cycle
// and presents the two oldest instructions to decode, which may take 0..2 per cycle.
module instr_queue #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  instr_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PTR_W-1:0]  wr_ptr1;
  logic [PTR_W-1:0]  rd_ptr1;
  logic              ready;
  logic              push;
  logic [CNT_W-1:0]  pop_req;
  logic [CNT_W-1:0]  pe;

  assign wr_ptr1 = wr_ptr_q + PTR_W'(1);
  assign rd_ptr1 = rd_ptr_q + PTR_W'(1);

  // Free-space test looks only at registered occupancy, so decode's pop never reaches fetch.
  assign ready = (cnt_q <= CNT_W'(DEPTH - 2));
  assign push  = q.inst_valid_i && ready;

  always_comb begin
    pop_req = (q.pop_i == 2'd0) ? CNT_W'(0) :
              (q.pop_i == 2'd1) ? CNT_W'(1) : CNT_W'(2);
    pe = (pop_req > cnt_q) ? cnt_q : pop_req;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (q.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(2);
      end
      rd_ptr_d = rd_ptr_q + PTR_W'(pe);
      cnt_d    = cnt_q + (push ? CNT_W'(2) : CNT_W'(0)) - pe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Each entry owns its own write port so a pair may straddle the wrap point.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (!rst) begin
          mem_q[gi] <= '0;
        end else if (push && !q.flush_i) begin
          if (wr_ptr_q == PTR_W'(gi)) begin
            mem_q[gi] <= q.inst0_i;
          end else if (wr_ptr1 == PTR_W'(gi)) begin
            mem_q[gi] <= q.inst1_i;
          end
        end
      end
    end
  endgenerate

  assign q.ready_o      = ready;
  assign q.deq0_o       = mem_q[rd_ptr_q];
  assign q.deq1_o       = mem_q[rd_ptr1];
  assign q.deq0_valid_o = (cnt_q != '0);
  assign q.deq1_valid_o = (cnt_q >= CNT_W'(2));
  assign q.count_o      = cnt_q;
endmodule

// File: tb/tb_instr_queue.sv
// Directed-vector bench for instr_queue: fill, mixed push/pop, wrap, pop clamp,
// and flush/reset priority, each with hand-computed expectations.
module tb_instr_queue;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  instr_queue_if #(.INST_W(32), .CNT_W(4)) qif ();

  instr_queue #(.DEPTH(8), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Apply one cycle of stimulus; returns 1ns after the edge so outputs are settled.
  task automatic cyc(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [1:0] p, input logic f, input logic r);
    qif.inst_valid_i = v;
    qif.inst0_i      = i0;
    qif.inst1_i      = i1;
    qif.pop_i        = p;
    qif.flush_i      = f;
    rst              = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] p);
    cyc(1'b0, 32'h0, 32'h0, p, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] p);
    cyc(1'b1, i0, i1, p, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    qif.inst_valid_i = 1'b0;
    qif.inst0_i = '0;
    qif.inst1_i = '0;
    qif.pop_i   = '0;
    qif.flush_i = 1'b0;
    rst = 1'b0;
    #2;

    // T1 reset
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    check("t1_count", 32'(qif.count_o), 32'd0);
    check("t1_ready", 32'(qif.ready_o), 32'd1);
    check("t1_v0",    32'(qif.deq0_valid_o), 32'd0);
    check("t1_v1",    32'(qif.deq1_valid_o), 32'd0);
    check("t1_deq0",  qif.deq0_o, 32'h0);

    // T2 fill with four packets, fifth is refused
    push(32'hA0, 32'hA1, 2'd0);
    check("t2_lat_deq0", qif.deq0_o, 32'hA0);
    push(32'hB0, 32'hB1, 2'd0);
    push(32'hC0, 32'hC1, 2'd0);
    push(32'hD0, 32'hD1, 2'd0);
    check("t2_count", 32'(qif.count_o), 32'd8);
    check("t2_ready", 32'(qif.ready_o), 32'd0);
    check("t2_deq0",  qif.deq0_o, 32'hA0);
    check("t2_deq1",  qif.deq1_o, 32'hA1);
    push(32'hE0, 32'hE1, 2'd0);
    check("t2_no_push_count", 32'(qif.count_o), 32'd8);
    check("t2_no_push_deq0",  qif.deq0_o, 32'hA0);

    // T3 mixed: down to 6, then push+pop1 -> 7, then pop2 -> 5
    idle(2'd2);
    check("t3_count6", 32'(qif.count_o), 32'd6);
    check("t3_deq0_b0", qif.deq0_o, 32'hB0);
    push(32'hF0, 32'hF1, 2'd1);
    check("t3_count7", 32'(qif.count_o), 32'd7);
    check("t3_ready7", 32'(qif.ready_o), 32'd0);
    check("t3_deq0_b1", qif.deq0_o, 32'hB1);
    push(32'hE0, 32'hE1, 2'd2);
    check("t3_count5", 32'(qif.count_o), 32'd5);
    check("t3_ready5", 32'(qif.ready_o), 32'd1);
    check("t3_deq0_c1", qif.deq0_o, 32'hC1);
    check("t3_deq1_d0", qif.deq1_o, 32'hD0);

    // Drain remaining D1 F0 F1 to check order across the write wrap
    idle(2'd2);
    check("t3_deq0_d1", qif.deq0_o, 32'hD1);
    check("t3_deq1_f0", qif.deq1_o, 32'hF0);
    idle(2'd2);
    check("t3_deq0_f1", qif.deq0_o, 32'hF1);
    check("t3_v1_cnt1", 32'(qif.deq1_valid_o), 32'd0);
    idle(2'd1);
    check("t3_empty", 32'(qif.count_o), 32'd0);

    // T4 wrap: rd_ptr=2; fill G,H,J (J at 6,7), advance rd to 7, then X lands at 0,1
    push(32'h10, 32'h11, 2'd0);
    push(32'h20, 32'h21, 2'd0);
    push(32'h30, 32'h31, 2'd0);
    idle(2'd2);
    idle(2'd2);
    idle(2'd1);
    check("t4_rd7_deq0", qif.deq0_o, 32'h31);
    check("t4_cnt1", 32'(qif.count_o), 32'd1);
    push(32'h40, 32'h41, 2'd0);
    check("t4_deq0_j1", qif.deq0_o, 32'h31);
    check("t4_deq1_x0", qif.deq1_o, 32'h40);
    idle(2'd2);
    check("t4_deq0_x1", qif.deq0_o, 32'h41);
    check("t4_cnt_one", 32'(qif.count_o), 32'd1);

    // T5 clamp: pop2 at cnt=1, then pop3 on empty
    idle(2'd2);
    check("t5_count0", 32'(qif.count_o), 32'd0);
    check("t5_v0", 32'(qif.deq0_valid_o), 32'd0);
    idle(2'd3);
    check("t5_empty_pop3", 32'(qif.count_o), 32'd0);
    check("t5_ready", 32'(qif.ready_o), 32'd1);
    push(32'h50, 32'h51, 2'd0);
    check("t5_rd_adv", qif.deq0_o, 32'h50);

    // pop_i=3 with cnt>=2 behaves as 2
    push(32'h60, 32'h61, 2'd3);
    check("t5_pop3_cnt", 32'(qif.count_o), 32'd2);
    check("t5_pop3_deq0", qif.deq0_o, 32'h60);

    // T6 flush priority: reach 5, then push+pop2+flush
    push(32'h70, 32'h71, 2'd0);
    push(32'h80, 32'h81, 2'd1);
    check("t6_count5", 32'(qif.count_o), 32'd5);
    cyc(1'b1, 32'h90, 32'h91, 2'd2, 1'b1, 1'b1);
    check("t6_flush_count", 32'(qif.count_o), 32'd0);
    check("t6_flush_v0", 32'(qif.deq0_valid_o), 32'd0);
    check("t6_flush_v1", 32'(qif.deq1_valid_o), 32'd0);
    check("t6_flush_ready", 32'(qif.ready_o), 32'd1);
    push(32'hA5, 32'hA6, 2'd0);
    check("t6_post_flush_deq0", qif.deq0_o, 32'hA5);
    push(32'hB5, 32'hB6, 2'd0);
    push(32'hC5, 32'hC6, 2'd1);
    check("t6_count5b", 32'(qif.count_o), 32'd5);
    // Reset together with flush: mem cleared, so deq0 reads 0 not A6/A5
    cyc(1'b1, 32'hD5, 32'hD6, 2'd2, 1'b1, 1'b0);
    check("t6_rst_count", 32'(qif.count_o), 32'd0);
    check("t6_rst_deq0", qif.deq0_o, 32'h0);
    check("t6_rst_deq1", qif.deq1_o, 32'h0);
    check("t6_rst_v0", 32'(qif.deq0_valid_o), 32'd0);
    check("t6_rst_ready", 32'(qif.ready_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
